// File: rtl/usrt_tx.sv
// usrt_tx: FIFO-buffered transmitter that frames bytes (start, 8 data LSB first, stop)
// onto a synchronous serial link with a divided bit clock.
module usrt_tx #(
    parameter int DIV = 4,
    parameter int DEPTH = 4
) (
    input  logic       pClk,
    input  logic       pReset,
    input  logic       wEn,
    input  logic [7:0] pWData,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       ovr,
    output logic       uClk,
    output logic       uTxd
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = DIV > 1 ? $clog2(DIV) : 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count, countNext;
    logic [HW-1:0] halfCnt;
    logic [7:0] shreg;
    logic [2:0] bitIdx;
    logic halfEnd, bitEnd, canPush, pop;
    // uClk doubles as the half-bit phase: a bit ends when the high half expires
    always_comb begin
        halfEnd = halfCnt == HW'(DIV - 1);
        bitEnd = halfEnd && uClk;
        canPush = wEn && count != CW'(DEPTH);
        pop = count != '0 && (state == IDLE || (state == STOP && bitEnd));
        countNext = count + CW'(canPush) - CW'(pop);
    end
    always_ff @(posedge pClk)
        if (canPush) mem[wrPtr] <= pWData;
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            state <= IDLE;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            halfCnt <= '0;
            shreg <= '0;
            bitIdx <= '0;
            full <= 1'b0;
            empty <= 1'b1;
            busy <= 1'b0;
            ovr <= 1'b0;
            uClk <= 1'b0;
            uTxd <= 1'b1;
        end else begin
            ovr <= wEn && !canPush;
            count <= countNext;
            full <= countNext == CW'(DEPTH);
            empty <= countNext == '0;
            if (canPush) wrPtr <= wrPtr + 1'b1;
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
                shreg <= mem[rdPtr];
            end
            if (state != IDLE) begin
                halfCnt <= halfEnd ? '0 : halfCnt + 1'b1;
                if (halfEnd) uClk <= ~uClk;
            end
            case (state)
                IDLE: if (pop) begin
                    state <= START;
                    halfCnt <= '0;
                    uClk <= 1'b0;
                    uTxd <= 1'b0;
                    busy <= 1'b1;
                end
                START: if (bitEnd) begin
                    state <= DATA;
                    bitIdx <= '0;
                    uTxd <= shreg[0];
                end
                DATA: if (bitEnd) begin
                    if (bitIdx == 3'd7) begin
                        state <= STOP;
                        uTxd <= 1'b1;
                    end else begin
                        bitIdx <= bitIdx + 1'b1;
                        shreg <= shreg >> 1;
                        uTxd <= shreg[1];
                    end
                end
                STOP: if (bitEnd) begin
                    if (pop) begin
                        state <= START;
                        uTxd <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
